mc_phase_sequencer: RTL and testbench

- Sequential phase generator for the multi-cycle MIPS core.
- Produces the one-hot phase vector p[4:0] consumed by the control unit, and varies the phase path by instruction class.
- Stalls on memory handshakes, with a timeout.
- Sequences exceptions: ALU overflow, illegal opcode, memory timeout.
- Supports halt at instruction boundaries and keeps cycle/retired-instruction counters.

---
 rtl/mc_phase_sequencer.sv | 168 ++++++++++++++++
 tb/tb_mc_phase_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_phase_sequencer.sv
// Phase sequencer for the multi-cycle MIPS core: one-hot phase generation per instruction class,
// memory-handshake stalls with timeout, exception/halt sequencing and cycle/retire counters.
module mc_phase_sequencer #(
    parameter int CNT_WIDTH   = 32,
    parameter int TMO_WIDTH   = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           op,
    input  logic [5:0]           irfunc,
    input  logic [4:0]           regimm,
    input  logic                 error,
    input  logic                 mem_ready,
    input  logic                 halt_req,
    output logic [4:0]           p,
    output logic                 mem_req,
    output logic                 regwrite_en,
    output logic                 exc_valid,
    output logic [1:0]           exc_cause,
    output logic                 epc_write,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] instret_count
);

    typedef enum logic [2:0] {
        ST_P0, ST_P1, ST_P2, ST_P3, ST_P4, ST_EXC, ST_HALT
    } state_e;

    localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'(MEM_TIMEOUT - 1);

    state_e                 state_q, state_d;
    logic [TMO_WIDTH-1:0]   waitCnt_q, waitCnt_d;
    logic [1:0]             excCause_q, excCause_d;
    logic [CNT_WIDTH-1:0]   cycleCnt_q, instretCnt_q;
    logic                   retire;
    logic                   isCalc, isAddSub, isBr, isJmp, isLw, isSw, isMem, isIllegal;

    always_comb begin
        isCalc   = 1'b0;
        isAddSub = 1'b0;
        isBr     = 1'b0;
        isJmp    = 1'b0;
        case (op)
            6'b000000: begin
                case (irfunc)
                    6'b100000, 6'b100010: begin
                        isCalc   = 1'b1;
                        isAddSub = 1'b1;
                    end
                    6'b100011, 6'b100100, 6'b100101, 6'b100110,
                    6'b100111, 6'b101010, 6'b101011: isCalc = 1'b1;
                    6'b001000, 6'b001001:            isJmp  = 1'b1;
                    default: ;
                endcase
            end
            6'b001001, 6'b001100, 6'b001101,
            6'b001110, 6'b001010, 6'b001011: isCalc = 1'b1;
            6'b000100, 6'b000101, 6'b000110, 6'b000111: isBr = 1'b1;
            6'b000001: isBr  = (regimm == 5'b00000) || (regimm == 5'b00001);
            6'b000010, 6'b000011: isJmp = 1'b1;
            default: ;
        endcase
        isLw      = (op == 6'b100011);
        isSw      = (op == 6'b101011);
        isMem     = isLw || isSw;
        isIllegal = !(isCalc || isBr || isJmp || isMem);
    end

    // Next state and Moore outputs; a retiring path funnels through the shared boundary check below.
    always_comb begin
        state_d     = state_q;
        waitCnt_d   = '0;
        excCause_d  = excCause_q;
        retire      = 1'b0;
        p           = 5'b00000;
        mem_req     = 1'b0;
        regwrite_en = 1'b0;
        exc_valid   = 1'b0;
        epc_write   = 1'b0;
        halted      = 1'b0;
        case (state_q)
            ST_P0: begin
                p       = 5'b00001;
                mem_req = 1'b1;
                if (mem_ready) begin
                    state_d = ST_P1;
                end else if (waitCnt_q == TMO_LAST) begin
                    state_d    = ST_EXC;
                    excCause_d = 2'd3;
                end else begin
                    waitCnt_d = waitCnt_q + TMO_WIDTH'(1);
                end
            end
            ST_P1: begin
                p = 5'b00010;
                if (isIllegal) begin
                    state_d    = ST_EXC;
                    excCause_d = 2'd2;
                end else begin
                    state_d = ST_P2;
                end
            end
            ST_P2: begin
                p = 5'b00100;
                if (isMem)     state_d = ST_P3;
                else if (isBr) retire  = 1'b1;
                else           state_d = ST_P4;
            end
            ST_P3: begin
                p       = 5'b01000;
                mem_req = isMem;
                if (mem_ready) begin
                    if (isLw) state_d = ST_P4;
                    else      retire  = 1'b1;
                end else if (waitCnt_q == TMO_LAST) begin
                    state_d    = ST_EXC;
                    excCause_d = 2'd3;
                end else begin
                    waitCnt_d = waitCnt_q + TMO_WIDTH'(1);
                end
            end
            ST_P4: begin
                p = 5'b10000;
                if (error && isAddSub) begin
                    state_d    = ST_EXC;
                    excCause_d = 2'd1;
                end else begin
                    regwrite_en = 1'b1;
                    retire      = 1'b1;
                end
            end
            ST_EXC: begin
                exc_valid = 1'b1;
                epc_write = 1'b1;
                state_d   = halt_req ? ST_HALT : ST_P0;
            end
            ST_HALT: begin
                halted = 1'b1;
                if (!halt_req) state_d = ST_P0;
            end
            default: state_d = ST_P0;
        endcase
        if (retire) state_d = halt_req ? ST_HALT : ST_P0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_P0;
            waitCnt_q    <= '0;
            excCause_q   <= 2'd0;
            cycleCnt_q   <= '0;
            instretCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            waitCnt_q  <= waitCnt_d;
            excCause_q <= excCause_d;
            if (state_q != ST_HALT) cycleCnt_q <= cycleCnt_q + CNT_WIDTH'(1);
            if (retire) instretCnt_q <= instretCnt_q + CNT_WIDTH'(1);
        end
    end

    assign exc_cause     = excCause_q;
    assign cycle_count   = cycleCnt_q;
    assign instret_count = instretCnt_q;

endmodule

// File: tb/tb_mc_phase_sequencer.sv
// Directed bench for mc_phase_sequencer: walks each phase path, stalls, exceptions, halt,
// mid-stall reset and counter wrap (second instance with 4-bit counters).
module tb_mc_phase_sequencer;

    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BAD   = 6'b111111;

    logic        clk, reset;
    logic [5:0]  op, irfunc;
    logic [4:0]  regimm;
    logic        error, mem_ready, halt_req;

    logic [4:0]  p;
    logic        mem_req, regwrite_en, exc_valid, epc_write, halted;
    logic [1:0]  exc_cause;
    logic [31:0] cycle_count, instret_count;

    logic [4:0]  nP;
    logic        nMemReq, nRegwriteEn, nExcValid, nEpcWrite, nHalted;
    logic [1:0]  nExcCause;
    logic [3:0]  nCycleCount, nInstretCount;

    int vectorCount = 0;
    int missCount   = 0;

    mc_phase_sequencer dut (
        .clk(clk), .reset(reset), .op(op), .irfunc(irfunc), .regimm(regimm),
        .error(error), .mem_ready(mem_ready), .halt_req(halt_req),
        .p(p), .mem_req(mem_req), .regwrite_en(regwrite_en), .exc_valid(exc_valid),
        .exc_cause(exc_cause), .epc_write(epc_write), .halted(halted),
        .cycle_count(cycle_count), .instret_count(instret_count)
    );

    mc_phase_sequencer #(.CNT_WIDTH(4)) dutNarrow (
        .clk(clk), .reset(reset), .op(op), .irfunc(irfunc), .regimm(regimm),
        .error(error), .mem_ready(mem_ready), .halt_req(halt_req),
        .p(nP), .mem_req(nMemReq), .regwrite_en(nRegwriteEn), .exc_valid(nExcValid),
        .exc_cause(nExcCause), .epc_write(nEpcWrite), .halted(nHalted),
        .cycle_count(nCycleCount), .instret_count(nInstretCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] opV, input logic [5:0] funcV,
                                 input logic readyV, input logic haltV, input logic errorV);
        op        = opV;
        irfunc    = funcV;
        regimm    = 5'b00000;
        mem_ready = readyV;
        halt_req  = haltV;
        error     = errorV;
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic checkPhase(input string tag, input logic [4:0] pExp, input logic memReqExp, input logic rwExp);
        checkOutput({tag, ".p"}, 32'(p), 32'(pExp));
        checkOutput({tag, ".mem_req"}, 32'(mem_req), 32'(memReqExp));
        checkOutput({tag, ".regwrite_en"}, 32'(regwrite_en), 32'(rwExp));
    endtask

    task automatic checkExc(input string tag, input logic [1:0] causeExp);
        checkOutput({tag, ".p"}, 32'(p), 32'd0);
        checkOutput({tag, ".exc_valid"}, 32'(exc_valid), 32'd1);
        checkOutput({tag, ".epc_write"}, 32'(epc_write), 32'd1);
        checkOutput({tag, ".exc_cause"}, 32'(exc_cause), 32'(causeExp));
        checkOutput({tag, ".mem_req"}, 32'(mem_req), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(OP_ADDIU, 6'd0, 1'b1, 1'b0, 1'b0);
        #11;
        checkPhase("reset", 5'b00001, 1'b1, 1'b0);
        checkOutput("reset.cycle", cycle_count, 32'd0);
        checkOutput("reset.instret", instret_count, 32'd0);
        checkOutput("reset.cause", 32'(exc_cause), 32'd0);
        checkOutput("reset.exc_valid", 32'(exc_valid), 32'd0);
        checkOutput("reset.epc_write", 32'(epc_write), 32'd0);
        checkOutput("reset.halted", 32'(halted), 32'd0);
        checkOutput("reset.narrow.instret", 32'(nInstretCount), 32'd0);
        #1 reset = 1'b1;

        // addiu: P0 P1 P2 P4
        tick; checkPhase("addiu.p1", 5'b00010, 1'b0, 1'b0);
        tick; checkPhase("addiu.p2", 5'b00100, 1'b0, 1'b0);
        tick; checkPhase("addiu.p4", 5'b10000, 1'b0, 1'b1);
        checkOutput("addiu.p4.instret", instret_count, 32'd0);
        tick; checkPhase("addiu.end", 5'b00001, 1'b1, 1'b0);
        checkOutput("addiu.instret", instret_count, 32'd1);
        checkOutput("addiu.cycle", cycle_count, 32'd4);

        // lw with three stalled P3 cycles
        applyStimulus(OP_LW, 6'd0, 1'b1, 1'b0, 1'b0);
        tick; tick; tick; checkPhase("lw.p3", 5'b01000, 1'b1, 1'b0);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick; checkPhase("lw.stall", 5'b01000, 1'b1, 1'b0);
        end
        mem_ready = 1'b1;
        tick; checkPhase("lw.p4", 5'b10000, 1'b0, 1'b1);
        tick; checkPhase("lw.end", 5'b00001, 1'b1, 1'b0);
        checkOutput("lw.instret", instret_count, 32'd2);
        checkOutput("lw.cycle", cycle_count, 32'd12);

        // add overflow
        applyStimulus(OP_RTYPE, 6'b100000, 1'b1, 1'b0, 1'b0);
        tick; tick; tick; error = 1'b1; #1;
        checkPhase("add.p4", 5'b10000, 1'b0, 1'b0);
        tick; error = 1'b0;
        checkExc("add.exc", 2'd1);
        checkOutput("add.exc.instret", instret_count, 32'd2);
        tick; checkPhase("add.p0", 5'b00001, 1'b1, 1'b0);
        checkOutput("add.after.exc_valid", 32'(exc_valid), 32'd0);
        checkOutput("add.after.cause", 32'(exc_cause), 32'd1);
        checkOutput("add.instret", instret_count, 32'd2);
        checkOutput("add.cycle", cycle_count, 32'd17);

        // subu ignores the overflow flag
        applyStimulus(OP_RTYPE, 6'b100011, 1'b1, 1'b0, 1'b0);
        tick; tick; tick; error = 1'b1; #1;
        checkPhase("subu.p4", 5'b10000, 1'b0, 1'b1);
        tick; error = 1'b0;
        checkPhase("subu.end", 5'b00001, 1'b1, 1'b0);
        checkOutput("subu.instret", instret_count, 32'd3);

        // fetch timeout after 15 stalled cycles
        mem_ready = 1'b0;
        repeat (14) tick;
        checkPhase("tmo.wait", 5'b00001, 1'b1, 1'b0);
        checkOutput("tmo.wait.exc_valid", 32'(exc_valid), 32'd0);
        tick; checkExc("tmo.exc", 2'd3);
        mem_ready = 1'b1;
        tick; checkPhase("tmo.p0", 5'b00001, 1'b1, 1'b0);
        checkOutput("tmo.cycle", cycle_count, 32'd37);
        checkOutput("tmo.instret", instret_count, 32'd3);

        // ready arriving on the 15th stalled cycle wins
        mem_ready = 1'b0;
        repeat (14) tick;
        mem_ready = 1'b1;
        tick; checkPhase("late.p1", 5'b00010, 1'b0, 1'b0);
        checkOutput("late.exc_valid", 32'(exc_valid), 32'd0);
        checkOutput("late.cause", 32'(exc_cause), 32'd3);
        tick; tick; tick;
        checkOutput("late.instret", instret_count, 32'd4);
        checkOutput("late.cycle", cycle_count, 32'd55);

        // illegal opcode
        applyStimulus(OP_BAD, 6'd0, 1'b1, 1'b0, 1'b0);
        tick; checkPhase("ill.p1", 5'b00010, 1'b0, 1'b0);
        tick; checkExc("ill.exc", 2'd2);
        tick; checkPhase("ill.p0", 5'b00001, 1'b1, 1'b0);
        checkOutput("ill.instret", instret_count, 32'd4);
        checkOutput("ill.cycle", cycle_count, 32'd58);

        // beq with halt at the boundary
        applyStimulus(OP_BEQ, 6'd0, 1'b1, 1'b0, 1'b0);
        tick; tick; checkPhase("beq.p2", 5'b00100, 1'b0, 1'b0);
        halt_req = 1'b1;
        tick;
        checkOutput("halt.halted", 32'(halted), 32'd1);
        checkPhase("halt", 5'b00000, 1'b0, 1'b0);
        checkOutput("halt.instret", instret_count, 32'd5);
        checkOutput("halt.cycle", cycle_count, 32'd61);
        tick; tick;
        checkOutput("halt.frozen.cycle", cycle_count, 32'd61);
        checkOutput("halt.frozen.halted", 32'(halted), 32'd1);
        halt_req = 1'b0;
        tick; checkPhase("unhalt.p0", 5'b00001, 1'b1, 1'b0);
        checkOutput("unhalt.halted", 32'(halted), 32'd0);
        checkOutput("unhalt.cycle", cycle_count, 32'd61);

        // asynchronous reset during a P3 stall
        applyStimulus(OP_LW, 6'd0, 1'b1, 1'b0, 1'b0);
        tick; checkOutput("lw2.cycle", cycle_count, 32'd62);
        tick; tick; mem_ready = 1'b0;
        tick; checkPhase("lw2.stall", 5'b01000, 1'b1, 1'b0);
        #1 reset = 1'b0;
        #1;
        checkPhase("areset", 5'b00001, 1'b1, 1'b0);
        checkOutput("areset.cycle", cycle_count, 32'd0);
        checkOutput("areset.instret", instret_count, 32'd0);
        checkOutput("areset.cause", 32'(exc_cause), 32'd0);
        checkOutput("areset.exc_valid", 32'(exc_valid), 32'd0);
        applyStimulus(OP_ADDIU, 6'd0, 1'b1, 1'b0, 1'b0);
        #1 reset = 1'b1;

        // 16 addiu instructions: 4-bit counters wrap to zero
        for (int i = 0; i < 16; i++) repeat (4) tick;
        checkPhase("wrap.p0", 5'b00001, 1'b1, 1'b0);
        checkOutput("wrap.instret", instret_count, 32'd16);
        checkOutput("wrap.cycle", cycle_count, 32'd64);
        checkOutput("wrap.narrow.instret", 32'(nInstretCount), 32'd0);
        checkOutput("wrap.narrow.cycle", 32'(nCycleCount), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
